// File: rtl/rtl_kernel_wizard_1_example_number_checker_pkg.sv
// ---------------------------------------------------------------------------
// rtl_kernel_wizard_1_example_number_checker_pkg
// Shared types and constant helpers for the number checker:
//   state_t            - checker FSM states
//   calc_num_beats     - beats per transfer (length rounded up to whole beats)
//   calc_final_keep    - tkeep expected on the last beat
//   calc_expected_lane - value carried by lane n of beat b, before truncation
// ---------------------------------------------------------------------------
package rtl_kernel_wizard_1_example_number_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Widest keep vector calc_final_keep can describe (4096-bit stream).
    localparam int MAX_KEEP_W = 512;

    function automatic logic [31:0] calc_num_beats(input int len_bytes, input int bytes_per_beat);
        return 32'((len_bytes + bytes_per_beat - 1) / bytes_per_beat);
    endfunction

    // Partial last beat keeps only its low bytes; an exact fit keeps everything.
    function automatic logic [MAX_KEEP_W-1:0] calc_final_keep(input int len_bytes, input int bytes_per_beat);
        int                    rem;
        logic [MAX_KEEP_W-1:0] keep;
        rem  = len_bytes % bytes_per_beat;
        keep = '0;
        for (int i = 0; i < MAX_KEEP_W; i++) begin
            if ((i < bytes_per_beat) && ((rem == 0) || (i < rem))) begin
                keep[i] = 1'b1;
            end
        end
        return keep;
    endfunction

    // Caller truncates to the lane width; wrap-around is part of the pattern.
    function automatic logic [63:0] calc_expected_lane(input logic [31:0] beat, input int lane, input int sb);
        return ({32'd0, beat} << sb) | 64'(lane);
    endfunction

endpackage

// File: rtl/rtl_kernel_wizard_1_example_number_checker_lane.sv
// ---------------------------------------------------------------------------
// rtl_kernel_wizard_1_example_number_checker_lane
// Combinational compare of one NB-bit lane against its expected value.
// Only bytes whose keep bit is set take part in the compare.
//   act_val  in  NB    lane data from the stream
//   exp_val  in  NB    expected lane value
//   keep     in  NB/8  byte enables for this lane
//   lane_err out 1     a kept byte differs
// ---------------------------------------------------------------------------
module rtl_kernel_wizard_1_example_number_checker_lane #(
    parameter int NB = 32
) (
    input  logic [NB-1:0]   act_val,
    input  logic [NB-1:0]   exp_val,
    input  logic [NB/8-1:0] keep,
    output logic            lane_err
);

    logic [NB-1:0] byte_mask;

    for (genvar i = 0; i < NB / 8; i++) begin : g_mask
        assign byte_mask[i*8 +: 8] = {8{keep[i]}};
    end

    assign lane_err = |((act_val ^ exp_val) & byte_mask);

endmodule

// File: rtl/rtl_kernel_wizard_1_example_number_checker.sv
// ---------------------------------------------------------------------------
// rtl_kernel_wizard_1_example_number_checker
// AXI4-Stream sink that checks one transfer of incrementing numbers from the
// example number generator and reports the outcome.
//   aclk, areset_n       clock, asynchronous active-low reset
//   ap_start / ap_done   rising edge arms a check / one-cycle completion pulse
//   s_axis_*             stream input (tvalid, tready, tdata, tkeep, tlast)
//   error_count          saturating count of erroneous beats
//   mismatch             sticky: at least one erroneous beat this run
//   first_err_beat       beat index of the first erroneous beat, 0 if none
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | tready low, waiting for a rising edge on ap_start
// RUN     | tready high, checking each accepted beat
// DONE    | ap_done high for this single cycle, then back to IDLE
// ---------------------------------------------------------------------------
module rtl_kernel_wizard_1_example_number_checker
    import rtl_kernel_wizard_1_example_number_checker_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 128,
    parameter int C_NUMBER_BIT_WIDTH   = 32,
    parameter int C_LENGTH_IN_BYTES    = 16384
) (
    input  logic                              aclk,
    input  logic                              areset_n,
    input  logic                              ap_start,
    output logic                              ap_done,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                              s_axis_tlast,
    output logic [31:0]                       error_count,
    output logic                              mismatch,
    output logic [31:0]                       first_err_beat
);

    localparam int NB  = (C_NUMBER_BIT_WIDTH < C_S_AXIS_TDATA_WIDTH) ? C_NUMBER_BIT_WIDTH
                                                                     : C_S_AXIS_TDATA_WIDTH;
    localparam int NL  = C_S_AXIS_TDATA_WIDTH / NB;
    localparam int SB  = (NL > 1) ? $clog2(NL) : 0;
    localparam int KW  = C_S_AXIS_TDATA_WIDTH / 8;
    localparam int NBB = NB / 8;

    localparam logic [31:0]   NUM_BEATS  = calc_num_beats(C_LENGTH_IN_BYTES, KW);
    localparam logic [KW-1:0] FINAL_KEEP = KW'(calc_final_keep(C_LENGTH_IN_BYTES, KW));

    state_t      state_q, state_d;
    logic [31:0] beat_q, beat_d;
    logic [31:0] error_count_q, error_count_d;
    logic        mismatch_q, mismatch_d;
    logic [31:0] first_err_beat_q, first_err_beat_d;
    logic        ap_start_q, ap_start_d;
    logic        tready_q, tready_d;
    logic        ap_done_q, ap_done_d;

    logic [NL-1:0] lane_err;
    logic          start_edge;
    logic          accept;
    logic          is_last;
    logic [KW-1:0] keep_exp;
    logic          beat_err;

    // Expected values follow beat_q, i.e. the beat currently on the bus.
    for (genvar n = 0; n < NL; n++) begin : g_lane
        logic [NB-1:0] exp_val;
        assign exp_val = NB'(calc_expected_lane(beat_q, n, SB));

        rtl_kernel_wizard_1_example_number_checker_lane #(
            .NB (NB)
        ) u_lane (
            .act_val  (s_axis_tdata[n*NB +: NB]),
            .exp_val  (exp_val),
            .keep     (s_axis_tkeep[n*NBB +: NBB]),
            .lane_err (lane_err[n])
        );
    end

    assign start_edge = ap_start & ~ap_start_q;
    assign accept     = s_axis_tvalid & tready_q;
    assign is_last    = (beat_q == NUM_BEATS - 32'd1);
    assign keep_exp   = is_last ? FINAL_KEEP : {KW{1'b1}};
    assign beat_err   = (|lane_err) | (s_axis_tkeep != keep_exp) | (s_axis_tlast != is_last);

    always_comb begin
        state_d          = state_q;
        beat_d           = beat_q;
        error_count_d    = error_count_q;
        mismatch_d       = mismatch_q;
        first_err_beat_d = first_err_beat_q;
        ap_start_d       = ap_start;

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d          = ST_RUN;
                    beat_d           = '0;
                    error_count_d    = '0;
                    mismatch_d       = 1'b0;
                    first_err_beat_d = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    beat_d = beat_q + 32'd1;
                    if (beat_err) begin
                        if (error_count_q != 32'hFFFF_FFFF) begin
                            error_count_d = error_count_q + 32'd1;
                        end
                        if (!mismatch_q) begin
                            mismatch_d       = 1'b1;
                            first_err_beat_d = beat_q;
                        end
                    end
                    // An early tlast ends the run just like the final beat.
                    if (is_last || s_axis_tlast) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tready_d  = (state_d == ST_RUN);
        ap_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q          <= ST_IDLE;
            beat_q           <= '0;
            error_count_q    <= '0;
            mismatch_q       <= 1'b0;
            first_err_beat_q <= '0;
            ap_start_q       <= 1'b0;
            tready_q         <= 1'b0;
            ap_done_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            beat_q           <= beat_d;
            error_count_q    <= error_count_d;
            mismatch_q       <= mismatch_d;
            first_err_beat_q <= first_err_beat_d;
            ap_start_q       <= ap_start_d;
            tready_q         <= tready_d;
            ap_done_q        <= ap_done_d;
        end
    end

    assign s_axis_tready  = tready_q;
    assign ap_done        = ap_done_q;
    assign error_count    = error_count_q;
    assign mismatch       = mismatch_q;
    assign first_err_beat = first_err_beat_q;

endmodule

// File: tb/tb_rtl_kernel_wizard_1_example_number_checker.sv
module tb_rtl_kernel_wizard_1_example_number_checker;

    localparam int          A_BEATS      = 1024;
    localparam int          B_LEN        = 20;
    localparam logic [15:0] B_FINAL_KEEP = 16'((1 << (B_LEN % 16)) - 1);
    localparam int          B_BEATS      = (B_LEN + 15) / 16;

    typedef struct packed {
        logic [31:0] cnt;
        logic        mm;
        logic [31:0] first;
    } exp_t;

    logic aclk = 1'b0;
    logic areset_n = 1'b0;

    logic         a_start = 1'b0, a_done, a_tvalid = 1'b0, a_tready, a_tlast = 1'b0, a_mm;
    logic [127:0] a_tdata = '0;
    logic [15:0]  a_tkeep = '0;
    logic [31:0]  a_cnt, a_first;

    logic         b_start = 1'b0, b_done, b_tvalid = 1'b0, b_tready, b_tlast = 1'b0, b_mm;
    logic [127:0] b_tdata = '0;
    logic [15:0]  b_tkeep = '0;
    logic [31:0]  b_cnt, b_first;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   failures = 0;

    always #5 aclk = ~aclk;

    rtl_kernel_wizard_1_example_number_checker dut_a (
        .aclk(aclk), .areset_n(areset_n), .ap_start(a_start), .ap_done(a_done),
        .s_axis_tvalid(a_tvalid), .s_axis_tready(a_tready), .s_axis_tdata(a_tdata),
        .s_axis_tkeep(a_tkeep), .s_axis_tlast(a_tlast), .error_count(a_cnt),
        .mismatch(a_mm), .first_err_beat(a_first)
    );

    rtl_kernel_wizard_1_example_number_checker #(
        .C_S_AXIS_TDATA_WIDTH(128), .C_NUMBER_BIT_WIDTH(32), .C_LENGTH_IN_BYTES(B_LEN)
    ) dut_b (
        .aclk(aclk), .areset_n(areset_n), .ap_start(b_start), .ap_done(b_done),
        .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready), .s_axis_tdata(b_tdata),
        .s_axis_tkeep(b_tkeep), .s_axis_tlast(b_tlast), .error_count(b_cnt),
        .mismatch(b_mm), .first_err_beat(b_first)
    );

    task automatic test_reset();
        areset_n = 1'b0;
        #1;
        checks++;
        if (a_tready !== 1'b0 || a_done !== 1'b0 || a_cnt !== 32'd0 || a_mm !== 1'b0 || a_first !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: tready=%b done=%b cnt=%0d mm=%b first=%0d, required all zero",
                     a_tready, a_done, a_cnt, a_mm, a_first);
        end
        repeat (2) @(negedge aclk);
        areset_n = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            checks++;
            if (a_tready !== 1'b0 || a_done !== 1'b0) begin
                failures++;
                $display("FAIL idle_without_start: tready=%b done=%b, required 0 0", a_tready, a_done);
            end
        end
    endtask

    // Drives one transfer into dut_a. The model scores each accepted beat and
    // pushes the expected results when the final/tlast beat is accepted.
    task automatic run_a(input string name, input int tlast_at, input int c0, input int c1,
                         input int gap_pct, input int restart_at, input int reset_at,
                         input bit hold_start);
        int          beat, cyc;
        bit          sending, done_due, finished, aborted, tr, berr;
        logic [31:0] m_cnt, m_first, lane_v;
        logic        m_mm;
        exp_t        e;
        beat = 0; cyc = 0; sending = 1; done_due = 0; finished = 0; aborted = 0;
        m_cnt = 0; m_first = 0; m_mm = 0;
        @(negedge aclk); a_start = 1'b0;
        @(negedge aclk); a_start = 1'b1;
        while (!finished) begin
            @(negedge aclk);
            cyc++;
            if (a_done === 1'b1) begin
                checks++;
                if (q_a.size() == 0) begin
                    failures++;
                    $display("FAIL %s_spurious_done: ap_done=1, required 0", name);
                end else begin
                    e = q_a.pop_front();
                    if (a_cnt !== e.cnt || a_mm !== e.mm || a_first !== e.first) begin
                        failures++;
                        $display("FAIL %s_results: cnt=%0d mm=%b first=%0d, required cnt=%0d mm=%b first=%0d",
                                 name, a_cnt, a_mm, a_first, e.cnt, e.mm, e.first);
                    end
                end
                finished = 1;
            end
            if (done_due) begin
                checks++;
                if (a_done !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_done_latency: ap_done=%b one cycle after final beat, required 1", name, a_done);
                end
                done_due = 0;
                finished = 1;
            end
            if (!finished && cyc > 6000) begin
                checks++; failures++;
                $display("FAIL %s_timeout: no ap_done after %0d cycles, required completion", name, cyc);
                finished = 1;
            end
            if (finished) break;
            if (cyc == 1 && !hold_start) a_start = 1'b0;
            if (sending && beat == restart_at) a_start = 1'b1;
            if (sending && beat == reset_at) begin
                a_tvalid = 1'b0; a_start = 1'b0; areset_n = 1'b0;
                #1;
                checks++;
                if (a_tready !== 1'b0 || a_done !== 1'b0 || a_cnt !== 32'd0) begin
                    failures++;
                    $display("FAIL %s_async_reset: tready=%b done=%b cnt=%0d, required 0 0 0",
                             name, a_tready, a_done, a_cnt);
                end
                repeat (3) @(negedge aclk);
                areset_n = 1'b1;
                repeat (5) begin
                    @(negedge aclk);
                    checks++;
                    if (a_done !== 1'b0 || a_tready !== 1'b0) begin
                        failures++;
                        $display("FAIL %s_aborted_done: done=%b tready=%b, required 0 0", name, a_done, a_tready);
                    end
                end
                aborted = 1;
                break;
            end
            tr = a_tready;
            if (sending && ($urandom_range(99) >= 32'(gap_pct))) begin
                a_tvalid = 1'b1;
                for (int n = 0; n < 4; n++) begin
                    lane_v = 32'(beat << 2) | 32'(n);
                    if (beat == c0 && n == 1) lane_v = lane_v + 32'd1;
                    if (beat == c1 && n == 0) lane_v = lane_v ^ 32'd1;
                    a_tdata[n*32 +: 32] = lane_v;
                end
                a_tkeep = 16'hFFFF;
                a_tlast = (beat == tlast_at) || (beat == A_BEATS - 1);
            end else begin
                a_tvalid = 1'b0;
            end
            if (a_tvalid && tr) begin
                berr = (beat == c0) || (beat == c1) || (a_tlast != (beat == A_BEATS - 1));
                if (berr) begin
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                    if (!m_mm) begin m_mm = 1'b1; m_first = 32'(beat); end
                end
                if (a_tlast) begin
                    e.cnt = m_cnt; e.mm = m_mm; e.first = m_first;
                    q_a.push_back(e);
                    sending = 0;
                    done_due = 1;
                end
                beat++;
            end
        end
        a_tvalid = 1'b0;
        if (!aborted) begin
            repeat (3) begin
                @(negedge aclk);
                checks++;
                if (a_done !== 1'b0 || a_tready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_post_done_idle: done=%b tready=%b, required 0 0", name, a_done, a_tready);
                end
            end
        end
        checks++;
        if (q_a.size() != 0) begin
            failures++;
            $display("FAIL %s_scoreboard_left: %0d entries, required 0", name, q_a.size());
            q_a.delete();
        end
    endtask

    task automatic test_ideal();           run_a("ideal",       -1, -1,  -1,  0,  -1,  -1, 1); endtask
    task automatic test_corrupt_lanes();   run_a("corrupt",     -1,  7, 900,  0,  -1,  -1, 0); endtask
    task automatic test_early_tlast();     run_a("early_tlast", 10, -1,  -1,  0,  -1,  -1, 0); endtask
    task automatic test_gaps_restart();    run_a("gaps",        -1, -1,  -1, 30, 400,  -1, 0); endtask
    task automatic test_reset_abort();     run_a("reset_abort", -1, -1,  -1,  0,  -1, 500, 0); endtask
    task automatic test_after_reset();     run_a("after_reset", -1, -1,  -1,  0,  -1,  -1, 0); endtask

    // dut_b: 20-byte transfer, two beats; beat 1 carries garbage above byte 3.
    task automatic test_short_length(input string name, input logic [15:0] keep1);
        int          beat, cyc;
        bit          finished, done_due, berr, tr;
        logic [31:0] m_cnt, m_first, lane_v;
        logic        m_mm;
        logic [7:0]  exp_byte;
        exp_t        e;
        beat = 0; cyc = 0; finished = 0; done_due = 0;
        m_cnt = 0; m_first = 0; m_mm = 0;
        @(negedge aclk); b_start = 1'b0;
        @(negedge aclk); b_start = 1'b1;
        while (!finished) begin
            @(negedge aclk);
            cyc++;
            if (done_due || b_done === 1'b1) begin
                checks++;
                if (b_done !== 1'b1 || q_b.size() == 0) begin
                    failures++;
                    $display("FAIL %s_done: ap_done=%b queued=%0d, required done=1 after final beat",
                             name, b_done, q_b.size());
                end else begin
                    e = q_b.pop_front();
                    if (b_cnt !== e.cnt || b_mm !== e.mm || b_first !== e.first) begin
                        failures++;
                        $display("FAIL %s_results: cnt=%0d mm=%b first=%0d, required cnt=%0d mm=%b first=%0d",
                                 name, b_cnt, b_mm, b_first, e.cnt, e.mm, e.first);
                    end
                end
                finished = 1;
            end else if (cyc > 100) begin
                checks++; failures++;
                $display("FAIL %s_timeout: no ap_done after %0d cycles, required completion", name, cyc);
                finished = 1;
            end
            if (finished) break;
            if (cyc == 1) b_start = 1'b0;
            tr = b_tready;
            b_tvalid = (beat < B_BEATS);
            for (int n = 0; n < 4; n++) begin
                lane_v = 32'(beat << 2) | 32'(n);
                if (beat == 1 && n != 0) lane_v = 32'hDEAD_BEEF ^ 32'(n);
                b_tdata[n*32 +: 32] = lane_v;
            end
            b_tkeep = (beat == B_BEATS - 1) ? keep1 : 16'hFFFF;
            b_tlast = (beat == B_BEATS - 1);
            if (b_tvalid && tr) begin
                berr = (b_tkeep != ((beat == B_BEATS - 1) ? B_FINAL_KEEP : 16'hFFFF));
                for (int i = 0; i < 16; i++) begin
                    lane_v   = 32'(beat << 2) | 32'(i / 4);
                    exp_byte = lane_v[(i % 4)*8 +: 8];
                    if (b_tkeep[i] && b_tdata[i*8 +: 8] != exp_byte) berr = 1;
                end
                if (berr) begin
                    m_cnt = m_cnt + 32'd1;
                    if (!m_mm) begin m_mm = 1'b1; m_first = 32'(beat); end
                end
                if (b_tlast) begin
                    e.cnt = m_cnt; e.mm = m_mm; e.first = m_first;
                    q_b.push_back(e);
                    done_due = 1;
                end
                beat++;
            end
        end
        b_tvalid = 1'b0;
        q_b.delete();
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_corrupt_lanes();
        test_short_length("short_keep_f",  16'h000F);
        test_short_length("short_keep_ff", 16'h00FF);
        test_early_tlast();
        test_gaps_restart();
        test_reset_abort();
        test_after_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtl_kernel_wizard_1_example_number_checker.md
Name: rtl_kernel_wizard_1_example_number_checker

Overview:
- AXI4-Stream sink placed directly downstream of the example number generator.
- Consumes one transfer of incrementing numbers and checks every lane, tkeep and tlast against the expected pattern.
- Reports an error count, a sticky mismatch flag and the beat index of the first error, then pulses ap_done.
- Used in loopback and hardware-emulation benches to self-check the generator / datapath.

Parameters:
C_S_AXIS_TDATA_WIDTH, 128, stream width in bits; multiple of C_NUMBER_BIT_WIDTH
C_NUMBER_BIT_WIDTH, 32, width of one number lane; clipped to C_S_AXIS_TDATA_WIDTH if larger
C_LENGTH_IN_BYTES, 16384, expected transfer length in bytes

Ports:
aclk  in  1  clock
areset_n  in  1  asynchronous active-low reset
ap_start  in  1  level; rising edge arms a new check
ap_done  out  1  one-cycle pulse when the check completes
s_axis_tvalid  in  1  stream valid
s_axis_tready  out  1  stream ready
s_axis_tdata  in  C_S_AXIS_TDATA_WIDTH  stream data
s_axis_tkeep  in  C_S_AXIS_TDATA_WIDTH/8  byte enables
s_axis_tlast  in  1  end of transfer
error_count  out  32  saturating count of erroneous beats
mismatch  out  1  sticky: at least one error this run
first_err_beat  out  32  beat index of the first erroneous beat; 0 if none

Behaviour:
Derived constants:
- NB = min(C_NUMBER_BIT_WIDTH, C_S_AXIS_TDATA_WIDTH)
- NL = C_S_AXIS_TDATA_WIDTH / NB
- SB = clog2(NL) if NL > 1, else 0
- NUM_BEATS = ceil(C_LENGTH_IN_BYTES / (C_S_AXIS_TDATA_WIDTH/8))
- FINAL_KEEP = (1 << (C_LENGTH_IN_BYTES mod bytes_per_beat)) - 1 when that remainder is non-zero; otherwise all ones.

Expected data:
- Lane n of beat b = ((b << SB) | n), truncated to NB bits. Wrap-around modulo 2^NB is expected, not an error.
- Data is compared only on bytes with tkeep=1.

Reset (areset_n low, asynchronous):
- State IDLE; s_axis_tready=0; ap_done=0; error_count=0; mismatch=0; first_err_beat=0; beat counter=0.
- ap_start edge-detect register cleared.
- Reset mid-run aborts silently; no ap_done is issued.

States:
- IDLE: tready=0. A rising edge of ap_start (ap_start & ~ap_start_r) moves to RUN and clears the beat counter, error_count, mismatch and first_err_beat in the same edge.
- RUN: tready=1. A beat is accepted when tvalid&tready. For each accepted beat b, it is erroneous if any of these holds:
  - a lane mismatches on a kept byte;
  - tkeep != (b==NUM_BEATS-1 ? FINAL_KEEP : all ones);
  - tlast != (b==NUM_BEATS-1).
- Error handling, per erroneous beat:
  - error_count increments by 1 per beat, not per lane, saturating at 0xFFFFFFFF.
  - On the first error, mismatch is set and first_err_beat is set to b.
- Leaving RUN: accepting beat NUM_BEATS-1, or accepting any beat with tlast=1 (early tlast), moves to DONE. tready drops the following cycle.
- DONE: ap_done=1 for exactly one cycle, then IDLE.
- Results (error_count, mismatch, first_err_beat) hold until the next start or reset.

Latency:
- Check results are registered at acceptance.
- ap_done is asserted the cycle after the final beat is accepted, with error_count already including that beat.

Boundary conditions:
- A rising edge of ap_start during RUN or DONE is ignored.
- ap_start held high does not retrigger.
- Idle cycles (tvalid=0) do not advance the beat counter.
- The beat counter is 32 bits, so its width never limits NUM_BEATS.
- NL=1 (SB=0): the expected value is b.

Decomposition:
- Package rtl_kernel_wizard_1_example_number_checker_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - functions computing NUM_BEATS, FINAL_KEEP and the expected lane value.
- Sub-module rtl_kernel_wizard_1_example_number_checker_lane: combinational compare of one NB-bit lane against its expected value, with a byte-mask input. It is instantiated NL times in a generate loop.

Test Plan:
- Defaults, ideal generator with tvalid always 1, 1024 beats (beat 0 = lanes 3..0: 3,2,1,0; beat 5 lane 2 = 22) -> ap_done one cycle after beat 1023; error_count=0; mismatch=0.
- Corrupt beat 7 lane 1 (value 29 -> 30) and beat 900 lane 0 -> error_count=2, first_err_beat=7, mismatch=1.
- C_LENGTH_IN_BYTES=20: 2 beats, final tkeep 0x000F, garbage in bytes 4..15 of beat 1 -> no error. Same run with final tkeep 0x00FF -> error_count=1, first_err_beat=1.
- tlast asserted on beat 10 of 1024 -> run ends, ap_done pulses, error_count=1, first_err_beat=10.
- Random tvalid gaps of 30% plus a second ap_start edge mid-run -> ignored; results identical to the ideal run.
- areset_n pulled low at beat 500, released, then restarted -> no ap_done from the aborted run; the new run passes with error_count=0.
